drum_line_bank: RTL

Parametrised, bit-serial recirculating drum memory bank for the G-15 core, generalising the fixed long-line memory group into LINES lines of WORDS words of BITS bits, all rotating in lockstep. It owns the drum position (word time, bit time), returns the bit under the read head of a selected line, and accepts bit-serial writes. Under a compile option it also provides a word-parallel host port for loading and dumping lines. It sits between the timing/control logic and the arithmetic/IO datapaths.

---
 rtl/drum_pkg.sv | 30 +++
 rtl/drum_line_bank_host_port.sv | 98 +++++++++
 rtl/drum_line_bank.sv | 138 +++++++++++++
 3 files changed

// File: rtl/drum_pkg.sv
// Shared constants, drum position type and host FSM states for the drum line bank.
package drum_pkg;

    localparam int unsigned DefLines = 20;
    localparam int unsigned DefWords = 108;
    localparam int unsigned DefBits  = 29;

    // Position fields are sized for the largest supported drum, not per instance.
    localparam int unsigned PosWordW = 16;
    localparam int unsigned PosBitW  = 8;

    typedef struct packed {
        logic [PosWordW-1:0] word;
        logic [PosBitW-1:0]  bit_pos;
    } drum_pos_t;

    typedef enum logic [1:0] {
        StIdle,
        StSeek,
        StXfer,
        StAck
    } host_state_e;

    function automatic int unsigned mem_index(input int unsigned line, input int unsigned word,
                                              input int unsigned bitn, input int unsigned words,
                                              input int unsigned bits);
        return (line * words + word) * bits + bitn;
    endfunction

endpackage

// File: rtl/drum_line_bank_host_port.sv
// Host word port: waits for the addressed word under the head, then moves BITS bits serially.
module drum_host_port
    import drum_pkg::*;
#(
    parameter int unsigned LINES = DefLines,
    parameter int unsigned WORDS = DefWords,
    parameter int unsigned BITS  = DefBits
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     bit_tick_i,
    input  drum_pos_t                pos_i,
    input  logic                     host_req_i,
    input  logic                     host_we_i,
    input  logic [$clog2(LINES)-1:0] host_line_i,
    input  logic [$clog2(WORDS)-1:0] host_word_i,
    input  logic [BITS-1:0]          host_wdata_i,
    input  logic                     mem_bit_i,
    output logic [$clog2(LINES)-1:0] line_o,
    output logic                     wr_en_o,
    output logic                     wr_bit_o,
    output logic [BITS-1:0]          host_rdata_o,
    output logic                     host_ack_o
);

    localparam logic [PosBitW-1:0] LastBit = PosBitW'(BITS - 1);

    host_state_e              state_q, state_d;
    logic [$clog2(LINES)-1:0] line_q, line_d;
    logic [PosWordW-1:0]      word_q, word_d;
    logic                     we_q, we_d;
    logic [BITS-1:0]          sr_q, sr_d;
    logic [BITS-1:0]          rdata_q, rdata_d;
    logic                     at_start;
    logic                     xfer_tick;

    // The tick that finds the head on bit 0 of the word already moves bit 0.
    assign at_start  = (pos_i.word == word_q) && (pos_i.bit_pos == '0);
    assign xfer_tick = bit_tick_i &&
                       (((state_q == StSeek) && at_start) || (state_q == StXfer));

    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        word_d  = word_q;
        we_d    = we_q;
        sr_d    = sr_q;
        rdata_d = rdata_q;
        case (state_q)
            StIdle: begin
                if (host_req_i) begin
                    line_d  = host_line_i;
                    word_d  = PosWordW'(host_word_i);
                    we_d    = host_we_i;
                    sr_d    = host_wdata_i;
                    state_d = StSeek;
                end
            end
            StSeek, StXfer: begin
                if (xfer_tick) begin
                    if (we_q) begin
                        sr_d = sr_q >> 1;
                    end else begin
                        rdata_d = {mem_bit_i, rdata_q[BITS-1:1]};
                    end
                    state_d = (pos_i.bit_pos == LastBit) ? StAck : StXfer;
                end
            end
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            line_q  <= '0;
            word_q  <= '0;
            we_q    <= 1'b0;
            sr_q    <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            word_q  <= word_d;
            we_q    <= we_d;
            sr_q    <= sr_d;
            rdata_q <= rdata_d;
        end
    end

    assign line_o       = line_q;
    assign wr_en_o      = xfer_tick && we_q;
    assign wr_bit_o     = sr_q[0];
    assign host_rdata_o = rdata_q;
    assign host_ack_o   = (state_q == StAck);

endmodule

// File: rtl/drum_line_bank.sv
// Bit-serial recirculating drum bank: owns drum position, serial read/write heads.
// Optional word-parallel host port is built when G15_HOST_PORT_EN is defined.
module drum_line_bank
    import drum_pkg::*;
#(
    parameter int unsigned LINES = DefLines,
    parameter int unsigned WORDS = DefWords,
    parameter int unsigned BITS  = DefBits
) (
    input  logic                     CLOCK,
    input  logic                     rst,
    input  logic                     bit_tick,
    input  logic [$clog2(LINES)-1:0] line_sel,
    output logic                     rd_bit,
    input  logic                     wr_en,
    input  logic [$clog2(LINES)-1:0] wr_line,
    input  logic                     wr_bit,
    output logic [$clog2(WORDS)-1:0] word_time,
    output logic [$clog2(BITS)-1:0]  bit_time,
    output logic                     word_mark,
    output logic                     origin_mark
`ifdef G15_HOST_PORT_EN
    ,
    input  logic                     host_req,
    input  logic                     host_we,
    input  logic [$clog2(LINES)-1:0] host_line,
    input  logic [$clog2(WORDS)-1:0] host_word,
    input  logic [BITS-1:0]          host_wdata,
    output logic [BITS-1:0]          host_rdata,
    output logic                     host_ack
`endif
);

    localparam int unsigned         Depth    = LINES * WORDS * BITS;
    localparam int unsigned         IdxW     = $clog2(Depth);
    localparam logic [PosBitW-1:0]  LastBit  = PosBitW'(BITS - 1);
    localparam logic [PosWordW-1:0] LastWord = PosWordW'(WORDS - 1);

    drum_pos_t                pos_q, pos_d;
    logic                     rd_bit_q, rd_bit_d;
    logic                     word_mark_q, word_mark_d;
    logic                     origin_mark_q, origin_mark_d;
    logic                     mem_q [Depth];
    logic [IdxW-1:0]          rd_idx, wr_idx, host_idx;
    logic                     host_wr_en, host_wr_bit, ser_wr_en;
    logic [$clog2(LINES)-1:0] host_wr_line;

    assign rd_idx   = IdxW'(mem_index(32'(line_sel), 32'(pos_q.word), 32'(pos_q.bit_pos),
                                      WORDS, BITS));
    assign wr_idx   = IdxW'(mem_index(32'(wr_line), 32'(pos_q.word), 32'(pos_q.bit_pos),
                                      WORDS, BITS));
    assign host_idx = IdxW'(mem_index(32'(host_wr_line), 32'(pos_q.word), 32'(pos_q.bit_pos),
                                      WORDS, BITS));

`ifdef G15_HOST_PORT_EN
    drum_host_port #(
        .LINES(LINES),
        .WORDS(WORDS),
        .BITS (BITS)
    ) u_host_port (
        .clk_i       (CLOCK),
        .rst_i       (rst),
        .bit_tick_i  (bit_tick),
        .pos_i       (pos_q),
        .host_req_i  (host_req),
        .host_we_i   (host_we),
        .host_line_i (host_line),
        .host_word_i (host_word),
        .host_wdata_i(host_wdata),
        .mem_bit_i   (mem_q[host_idx]),
        .line_o      (host_wr_line),
        .wr_en_o     (host_wr_en),
        .wr_bit_o    (host_wr_bit),
        .host_rdata_o(host_rdata),
        .host_ack_o  (host_ack)
    );
`else
    assign host_wr_en   = 1'b0;
    assign host_wr_bit  = 1'b0;
    assign host_wr_line = '0;
`endif

    // A host word write owns its line for the whole transfer; serial writes there are dropped.
    assign ser_wr_en = bit_tick && wr_en && !(host_wr_en && (host_wr_line == wr_line));

    always_comb begin
        pos_d         = pos_q;
        rd_bit_d      = rd_bit_q;
        word_mark_d   = 1'b0;
        origin_mark_d = 1'b0;
        if (bit_tick) begin
            rd_bit_d = mem_q[rd_idx];
            if (pos_q.bit_pos == LastBit) begin
                pos_d.bit_pos = '0;
                word_mark_d   = 1'b1;
                if (pos_q.word == LastWord) begin
                    pos_d.word    = '0;
                    origin_mark_d = 1'b1;
                end else begin
                    pos_d.word = pos_q.word + 1'b1;
                end
            end else begin
                pos_d.bit_pos = pos_q.bit_pos + 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst) begin
            pos_q         <= '0;
            rd_bit_q      <= 1'b0;
            word_mark_q   <= 1'b0;
            origin_mark_q <= 1'b0;
        end else begin
            pos_q         <= pos_d;
            rd_bit_q      <= rd_bit_d;
            word_mark_q   <= word_mark_d;
            origin_mark_q <= origin_mark_d;
        end
    end

    // Drum contents survive reset, so storage has no reset branch.
    always_ff @(posedge CLOCK) begin
        if (ser_wr_en) begin
            mem_q[wr_idx] <= wr_bit;
        end
        if (host_wr_en) begin
            mem_q[host_idx] <= host_wr_bit;
        end
    end

    assign rd_bit      = rd_bit_q;
    assign word_time   = pos_q.word[$clog2(WORDS)-1:0];
    assign bit_time    = pos_q.bit_pos[$clog2(BITS)-1:0];
    assign word_mark   = word_mark_q;
    assign origin_mark = origin_mark_q;

endmodule
